// File: rtl/uart_lite_initiator.sv
// uart_lite_initiator: host request port to packed AXI-Lite-style UART bus.
// One transaction in flight; registered outputs; optional completion timeout.
module uart_lite_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [2:0]  req_addr_i,
  input  logic [7:0]  req_wdata_i,
  output logic        rsp_valid_o,
  output logic [7:0]  rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic [31:0] CPU_to_UART,
  input  logic [31:0] UART_to_CPU
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, WRITE, WRESP, RADDR, RDATA
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          expire;
  logic          hs;

  logic          awvalid, wvalid, bready;
  logic          arvalid, rready;
  logic [2:0]    aw_addr, ar_addr;
  logic [7:0]    wd;

  logic          awready, wready, bvalid;
  logic          arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [7:0]    rdata;
  logic          unused_bits;

  assign awready = UART_to_CPU[0];
  assign wready  = UART_to_CPU[1];
  assign bvalid  = UART_to_CPU[2];
  assign bresp   = UART_to_CPU[4:3];
  assign arready = UART_to_CPU[5];
  assign rvalid  = UART_to_CPU[6];
  assign rresp   = UART_to_CPU[8:7];
  assign rdata   = UART_to_CPU[16:9];
  assign unused_bits = ^UART_to_CPU[31:17];

  assign CPU_to_UART = {12'd0, rready, ar_addr, arvalid,
                        1'b0, wd, bready, aw_addr,
                        wvalid, awvalid};

  // The counter value after this cycle reaching the limit ends the wait.
  assign cnt_nxt = cnt + CW'(1);
  assign expire  = (TIMEOUT_CYCLES != 0) &&
                   (cnt_nxt == CW'(TIMEOUT_CYCLES));

  // Handshake that advances the current state; it beats the timeout.
  always_comb begin
    hs = 1'b0;
    unique case (state)
      IDLE:  hs = 1'b0;
      WRITE: hs = (!awvalid || awready) &&
                  (!wvalid || wready);
      WRESP: hs = bvalid;
      RADDR: hs = arready;
      RDATA: hs = rvalid;
      default: hs = 1'b0;
    endcase
  end

  // Transaction FSM with all bus and response outputs registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      cnt           <= '0;
      awvalid       <= 1'b0;
      wvalid        <= 1'b0;
      bready        <= 1'b0;
      arvalid       <= 1'b0;
      rready        <= 1'b0;
      aw_addr       <= '0;
      ar_addr       <= '0;
      wd            <= '0;
      req_ready_o   <= 1'b1;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      if (state != IDLE) cnt <= cnt_nxt;
      if (state != IDLE && !hs && expire) begin
        awvalid       <= 1'b0;
        wvalid        <= 1'b0;
        bready        <= 1'b0;
        arvalid       <= 1'b0;
        rready        <= 1'b0;
        state         <= IDLE;
        req_ready_o   <= 1'b1;
        rsp_valid_o   <= 1'b1;
        rsp_rdata_o   <= '0;
        rsp_err_o     <= 1'b1;
        rsp_timeout_o <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (req_valid_i && req_ready_o) begin
              cnt         <= '0;
              req_ready_o <= 1'b0;
              if (req_write_i) begin
                state   <= WRITE;
                awvalid <= 1'b1;
                wvalid  <= 1'b1;
                aw_addr <= req_addr_i;
                wd      <= req_wdata_i;
                ar_addr <= '0;
              end else begin
                state   <= RADDR;
                arvalid <= 1'b1;
                ar_addr <= req_addr_i;
                aw_addr <= '0;
                wd      <= '0;
              end
            end
          end
          WRITE: begin
            if (awvalid && awready) awvalid <= 1'b0;
            if (wvalid && wready)   wvalid  <= 1'b0;
            if (hs) begin
              state  <= WRESP;
              bready <= 1'b1;
            end
          end
          WRESP: begin
            if (hs) begin
              state         <= IDLE;
              bready        <= 1'b0;
              req_ready_o   <= 1'b1;
              rsp_valid_o   <= 1'b1;
              rsp_rdata_o   <= '0;
              rsp_err_o     <= (bresp != 2'b00);
              rsp_timeout_o <= 1'b0;
            end
          end
          RADDR: begin
            if (hs) begin
              state   <= RDATA;
              arvalid <= 1'b0;
              rready  <= 1'b1;
            end
          end
          RDATA: begin
            if (hs) begin
              state         <= IDLE;
              rready        <= 1'b0;
              req_ready_o   <= 1'b1;
              rsp_valid_o   <= 1'b1;
              rsp_rdata_o   <= rdata;
              rsp_err_o     <= (rresp != 2'b00);
              rsp_timeout_o <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_lite_initiator.sv
// tb_uart_lite_initiator: directed stimulus with a response scoreboard.
// A delay-configurable UART model answers the packed bus.
module tb_uart_lite_initiator;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] bus;
  logic [31:0] ubus = '0;

  always #5 clk = ~clk;

  uart_lite_initiator #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_write_i   (req_write),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .rsp_valid_o   (rsp_valid),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_err_o     (rsp_err),
    .rsp_timeout_o (rsp_timeout),
    .CPU_to_UART   (bus),
    .UART_to_CPU   (ubus)
  );

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    logic       to;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  int         aw_d, w_d, b_d, ar_d, r_d;
  logic [1:0] m_bresp, m_rresp;
  logic [7:0] m_rdat;
  int         naw = 0, nw = 0, nb = 0, nar = 0, nr = 0;
  int         hs_b = 0;
  int         r_run = 0;
  logic [31:0] mb;
  logic [31:0] mu;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // UART model: each ready/valid rises once its partner has been
  // high for more than the configured number of cycles.
  always @(negedge clk) begin
    mb  = bus;
    naw = mb[0]  ? naw + 1 : 0;
    nw  = mb[1]  ? nw + 1  : 0;
    nb  = mb[5]  ? nb + 1  : 0;
    nar = mb[15] ? nar + 1 : 0;
    nr  = mb[19] ? nr + 1  : 0;
    mu = '0;
    mu[0]    = mb[0]  && (naw > aw_d);
    mu[1]    = mb[1]  && (nw > w_d);
    mu[2]    = mb[5]  && (nb > b_d);
    mu[4:3]  = m_bresp;
    mu[5]    = mb[15] && (nar > ar_d);
    mu[6]    = mb[19] && (nr > r_d);
    mu[8:7]  = m_rresp;
    mu[16:9] = m_rdat;
    if (mu[2]) hs_b = hs_b + 1;
    if (mu[6]) r_run = nr;
    ubus = mu;
  end

  // Monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_ni && rsp_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_timeout", rsp_timeout, e.to);
        chk("rsp_latency", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic cfg(input int a, input int w, input int b,
                     input int ar, input int r,
                     input logic [1:0] br, input logic [1:0] rr,
                     input logic [7:0] rd);
    aw_d = a; w_d = w; b_d = b; ar_d = ar; r_d = r;
    m_bresp = br; m_rresp = rr; m_rdat = rd;
  endtask

  task automatic issue(input bit w, input logic [2:0] a,
                       input logic [7:0] d, input bit push,
                       input logic [7:0] xr, input bit xe,
                       input bit xt, input int xl,
                       output int acc);
    exp_t e;
    logic rdy;
    int   n;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    acc = -1;
    n = 0;
    while (acc < 0 && n < 40) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      #1;
      if (rdy) acc = cyc;
      n++;
    end
    req_valid = 1'b0;
    if (acc < 0) begin
      chk("req_accept", 32'd0, 32'd1);
    end else if (push) begin
      e.rdata = xr;
      e.err   = xe;
      e.to    = xt;
      e.lat   = xl;
      e.acc   = acc;
      sbq.push_back(e);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      chk("rsp_arrived", 32'd0, 32'd1);
      sbq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a1, a2, h0, n;
    rst_ni    = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_bus", bus, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_timeout", rsp_timeout, 0);
    @(posedge clk);
    #1;

    // Write, UART always ready
    h0 = hs_b;
    issue(1, 3'd3, 8'h83, 1, 8'h00, 0, 0, 2, a1);
    @(negedge clk);
    chk("wr_bus_aw_w", bus, 32'h000020CF);
    @(negedge clk);
    chk("wr_bus_b", bus, 32'h000020EC);
    wait_done();
    chk("wr_b_count", hs_b - h0, 1);

    // Staggered write, error bresp
    cfg(0, 2, 0, 0, 0, 2'b11, 2'b00, 8'h00);
    h0 = hs_b;
    issue(1, 3'd6, 8'h5A, 1, 8'h00, 1, 0, 4, a1);
    @(negedge clk);
    chk("stag_bus_c1", bus, 32'h0000169B);
    @(negedge clk);
    chk("stag_bus_c2", bus, 32'h0000169A);
    @(negedge clk);
    chk("stag_bus_c3", bus, 32'h0000169A);
    wait_done();
    chk("stag_b_count", hs_b - h0, 1);

    // Read with delayed arready and rvalid
    cfg(0, 0, 0, 1, 3, 2'b00, 2'b00, 8'h60);
    issue(0, 3'd5, 8'h00, 1, 8'h60, 0, 0, 6, a1);
    @(negedge clk);
    chk("rd_bus_ar", bus, 32'h00058000);
    wait_done();
    chk("rd_rready_run", r_run, 4);

    // R handshake on the same edge the counter expires
    cfg(0, 0, 0, 0, 6, 2'b00, 2'b00, 8'hA5);
    issue(0, 3'd1, 8'h00, 1, 8'hA5, 0, 0, 8, a1);
    wait_done();

    // Timeout: arready never comes
    cfg(0, 0, 0, 1000, 0, 2'b00, 2'b00, 8'h00);
    issue(0, 3'd7, 8'h00, 1, 8'h00, 1, 1, 8, a1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    chk("to_rsp_seen", rsp_valid, 1);
    chk("to_arvalid_low", bus[15], 0);
    chk("to_ready", req_ready, 1);
    @(negedge clk);
    chk("to_arvalid_after", bus[15], 0);
    wait_done();

    // Error read right after the timeout
    cfg(0, 0, 0, 0, 0, 2'b00, 2'b10, 8'h3C);
    issue(0, 3'd2, 8'h00, 1, 8'h3C, 1, 0, 2, a1);
    wait_done();

    // Back-to-back: second request held through the first
    cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 8'h77);
    issue(1, 3'd1, 8'h11, 1, 8'h00, 0, 0, 2, a1);
    issue(0, 3'd4, 8'h00, 1, 8'h77, 0, 0, 2, a2);
    chk("b2b_gap", a2 - a1, 3);
    wait_done();

    // Reset while waiting in WRESP
    cfg(0, 0, 1000, 0, 0, 2'b00, 2'b00, 8'h00);
    issue(1, 3'd2, 8'h44, 0, 8'h00, 0, 0, 0, a1);
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_bready", bus[5], 1);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_bus", bus, 0);
    chk("rst_mid_rsp", rsp_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (12) @(posedge clk);
    #1;

    // Recovery write after reset
    cfg(0, 0, 0, 0, 0, 2'b00, 2'b00, 8'h00);
    issue(1, 3'd0, 8'hFF, 1, 8'h00, 0, 0, 2, a1);
    wait_done();

    chk("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
